// File: rtl/audio_i2s_rx.sv
// I2S capture front-end: oversamples the BCLK/LRCLK/SDATA pads, frames Philips I2S
// words, pairs left/right samples and queues them in a small FIFO on a valid/ready stream.
module audio_i2s_rx #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int FIFO_AW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata,
    output logic [2*SAMPLE_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  locked,
    output logic [7:0]            ovf_cnt,
    input  logic                  stat_clr
);

    localparam int BCNT_W = $clog2(SLOT_W + 1);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int PAIR_W = 2 * SAMPLE_W;

    logic [2:0] pad_in;
    logic [2:0] pad_sync;

    assign pad_in = {i2s_bclk, i2s_lrclk, i2s_sdata};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic s1_reg;
        logic s2_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
            end else begin
                s1_reg <= pad_in[gi];
                s2_reg <= s1_reg;
            end
        end
        assign pad_sync[gi] = s2_reg;
    end

    // LRCLK and SDATA are delayed alongside the edge detector so they line up with rise_reg.
    logic bclk_d_reg, rise_reg, lr_smp_reg, sd_smp_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_d_reg <= 1'b0;
            rise_reg   <= 1'b0;
            lr_smp_reg <= 1'b0;
            sd_smp_reg <= 1'b0;
        end else begin
            bclk_d_reg <= pad_sync[2];
            rise_reg   <= pad_sync[2] & ~bclk_d_reg;
            lr_smp_reg <= pad_sync[1];
            sd_smp_reg <= pad_sync[0];
        end
    end

    logic                lr_prev_reg, lr_prev_next;
    logic [BCNT_W-1:0]   bcnt_reg, bcnt_next;
    logic [SAMPLE_W-1:0] shreg_reg, shreg_next;
    logic                locked_reg, locked_next;
    logic                left_ok_reg, left_ok_next;
    logic [SAMPLE_W-1:0] left_hold_reg, left_hold_next;
    logic                push_reg, push_next;
    logic [PAIR_W-1:0]   push_data_reg, push_data_next;

    logic [SAMPLE_W-1:0] bit_sel;
    logic [SAMPLE_W-1:0] word;
    logic                boundary;

    // One-hot write position for the current bit; all zero once the index passes SAMPLE_W.
    for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_bit_sel
        assign bit_sel[SAMPLE_W-1-gi] = (32'(bcnt_reg) == gi);
    end

    assign word     = shreg_reg | (bit_sel & {SAMPLE_W{sd_smp_reg}});
    assign boundary = rise_reg && (lr_smp_reg != lr_prev_reg);

    always_comb begin
        lr_prev_next   = lr_prev_reg;
        bcnt_next      = bcnt_reg;
        shreg_next     = shreg_reg;
        locked_next    = locked_reg;
        left_ok_next   = left_ok_reg;
        left_hold_next = left_hold_reg;
        push_next      = 1'b0;
        push_data_next = push_data_reg;
        if (rise_reg) begin
            lr_prev_next = lr_smp_reg;
            if (boundary) begin
                bcnt_next  = '0;
                shreg_next = '0;
                if (!locked_reg) begin
                    locked_next = 1'b1;
                end else if (!lr_prev_reg) begin
                    left_hold_next = word;
                    left_ok_next   = 1'b1;
                end else if (left_ok_reg) begin
                    push_next      = 1'b1;
                    push_data_next = {left_hold_reg, word};
                    left_ok_next   = 1'b0;
                end
            end else begin
                shreg_next = word;
                if (bcnt_reg != BCNT_W'(SLOT_W)) begin
                    bcnt_next = bcnt_reg + BCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lr_prev_reg   <= 1'b0;
            bcnt_reg      <= '0;
            shreg_reg     <= '0;
            locked_reg    <= 1'b0;
            left_ok_reg   <= 1'b0;
            left_hold_reg <= '0;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
        end else begin
            lr_prev_reg   <= lr_prev_next;
            bcnt_reg      <= bcnt_next;
            shreg_reg     <= shreg_next;
            locked_reg    <= locked_next;
            left_ok_reg   <= left_ok_next;
            left_hold_reg <= left_hold_next;
            push_reg      <= push_next;
            push_data_reg <= push_data_next;
        end
    end

    logic [PAIR_W-1:0]  mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [PAIR_W-1:0]  out_data_reg;
    logic               out_valid_reg;
    logic [7:0]         ovf_cnt_reg;
    logic               fifo_full, pop, push_ok, drop;

    assign fifo_full   = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                         (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
    assign pop         = out_valid_reg & out_ready;
    assign push_ok     = push_reg & (~fifo_full | pop);
    assign drop        = push_reg & fifo_full & ~pop;
    assign rd_ptr_next = rd_ptr_reg + (FIFO_AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= push_data_reg;
        end
    end

    // The head is re-read every cycle from the post-pop address; a freshly written
    // entry becomes visible one cycle after its write, hence no bypass path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (FIFO_AW+1)'(1);
            end
            rd_ptr_reg    <= rd_ptr_next;
            out_data_reg  <= mem[rd_ptr_next[FIFO_AW-1:0]];
            out_valid_reg <= (wr_ptr_reg != rd_ptr_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            ovf_cnt_reg <= 8'd0;
        end else if (drop && (ovf_cnt_reg != 8'hFF)) begin
            ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign locked    = locked_reg;
    assign ovf_cnt   = ovf_cnt_reg;

endmodule
